// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings, FSM states, control flags.
// Latency: none (package only).
// Backpressure: not applicable.
package md_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Latched per-operation control: which engine, and which result halves get negated.
    typedef struct packed {
        logic is_div;
        logic neg_lo;
        logic neg_hi;
    } md_ctl_t;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is correct as unsigned.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
        return (sgn & v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// One restoring-divide step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; the caller registers the result every ITER cycle.
module md_div_iter (
    input  logic [31:0] rem,
    input  logic        dvd_bit,
    input  logic [31:0] dvs,
    output logic [31:0] rem_nxt,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // Partial remainder is always below the divisor, so the shifted value is below 2*divisor
    // and the trial difference fits in 33 bits with bit 32 acting as the borrow.
    always_comb begin
        shifted = {rem, dvd_bit};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[32];
        rem_nxt = q_bit ? diff[31:0] : shifted[31:0];
    end

endmodule

// File: rtl/md_sched.sv
// MIPS HI/LO owner: sequences MULT/MULTU/DIV/DIVU over a 32-step iterative engine, handles MTHI/MTLO.
// Latency: mul/div 33 cycles busy (divide-by-zero 1; MD_FAST_MULT_EN gives 2-cycle multiply); MTHI/MTLO next cycle.
// Backpressure: stall = busy & (req_valid | hilo_rd); a held request is taken in the done cycle; cancel aborts.
module md_sched
    import md_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        cancel,
    input  logic        hilo_rd,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state, state_nxt;
    logic [5:0]  cnt;
    logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd;     // multiplicand or divisor magnitude
    md_ctl_t     ctl, ctl_nxt;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        accept, mul_req, div_req, sgn_req, div_zero, last_iter;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_acc, div_acc, prod_neg;
    logic [31:0] div_rem, fix_hi, fix_lo;
    logic        div_q;

    assign busy     = (state != ST_IDLE);
    assign stall    = busy & (req_valid | hilo_rd);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    assign accept   = req_valid & ~cancel & (state == ST_IDLE);
    assign mul_req  = (req_op == MD_MULT) | (req_op == MD_MULTU);
    assign div_req  = (req_op == MD_DIV)  | (req_op == MD_DIVU);
    assign sgn_req  = (req_op == MD_MULT) | (req_op == MD_DIV);
    assign div_zero = div_req & (req_b == 32'd0);
    assign mag_a    = md_abs(req_a, sgn_req);
    assign mag_b    = md_abs(req_b, sgn_req);

`ifdef MD_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, opnd} * {32'd0, acc[31:0]};
    assign last_iter = ~ctl.is_div | (cnt == 6'(ITER - 1));
`else
    assign last_iter = (cnt == 6'(ITER - 1));
`endif

    md_div_iter u_div_iter (
        .rem     (acc[63:32]),
        .dvd_bit (acc[31]),
        .dvs     (opnd),
        .rem_nxt (div_rem),
        .q_bit   (div_q)
    );

    // Per-step engine results, sign-correction flags for a new request, and the final fixed result.
    always_comb begin
        mul_sum        = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_acc        = {mul_sum, acc[31:1]};
        div_acc        = {div_rem, acc[30:0], div_q};
        prod_neg       = ~acc + 64'd1;
        ctl_nxt.is_div = div_req;
        ctl_nxt.neg_lo = sgn_req & ~div_zero & (req_a[31] ^ req_b[31]);
        ctl_nxt.neg_hi = sgn_req & ~div_zero & (div_req ? req_a[31] : (req_a[31] ^ req_b[31]));
        if (ctl.is_div) begin
            fix_hi = ctl.neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
            fix_lo = ctl.neg_lo ? (~acc[31:0] + 32'd1)  : acc[31:0];
        end else begin
            fix_hi = ctl.neg_hi ? prod_neg[63:32] : acc[63:32];
            fix_lo = ctl.neg_lo ? prod_neg[31:0]  : acc[31:0];
        end
    end

    // Next-state logic: divide-by-zero skips the engine; cancel aborts from any busy state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && (mul_req || div_req)) state_nxt = div_zero ? ST_FIX : ST_ITER;
            ST_ITER: if (cancel) state_nxt = ST_IDLE;
                     else if (last_iter) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Datapath: operand capture on accept, one engine step per ITER cycle, HI/LO writeback in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            ctl    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_FIX) & ~cancel;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_op == MD_MTHI) hi_q <= req_a;
                        if (req_op == MD_MTLO) lo_q <= req_a;
                        if (mul_req || div_req) begin
                            cnt <= 6'd0;
                            ctl <= ctl_nxt;
                            if (div_zero) begin
                                acc <= {req_a, 32'hFFFF_FFFF};
                            end else if (div_req) begin
                                acc  <= {32'd0, mag_a};
                                opnd <= mag_b;
                            end else begin
                                acc  <= {32'd0, mag_b};
                                opnd <= mag_a;
                            end
                        end
                    end
                end
                ST_ITER: begin
                    cnt <= cnt + 6'd1;
`ifdef MD_FAST_MULT_EN
                    acc <= ctl.is_div ? div_acc : fast_prod;
`else
                    acc <= ctl.is_div ? div_acc : mul_acc;
`endif
                end
                ST_FIX: begin
                    if (!cancel) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Randomised and directed bench for md_sched against a 64-bit arithmetic reference model.
// Latency: checks busy-cycle counts and the done pulse per op.
// Backpressure: exercises held requests, hilo_rd stalls, cancel and mid-op reset.
module tb_md_sched;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req_valid, cancel, hilo_rd;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_hi, cur_lo;

    md_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .cancel    (cancel),
        .hilo_rd   (hilo_rd),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI, LO} from the MIPS rules using plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, b, hi0, lo0);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, lo0};
            3'd5: return {hi0, a};
            default: return {hi0, lo0};
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd0 || op == 3'd1) begin
`ifdef MD_FAST_MULT_EN
            return 2;
`else
            return 33;
`endif
        end
        if (op == 3'd2 || op == 3'd3) return (b == 32'd0) ? 1 : 33;
        return 0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after the accept edge; runs until busy drops, landing in the done cycle.
    task automatic wait_result(input string tag, input int nb, input logic [63:0] exp_hl);
        int n = 0;
        while (busy && n < 100) begin
            hilo_rd = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "/stall"}, {63'd0, stall}, {63'd0, req_valid | hilo_rd});
            chk({tag, "/hold"}, {hi, lo}, {cur_hi, cur_lo});
            hilo_rd = 1'b0;
            n++;
            @(posedge clk); #1;
        end
        chk({tag, "/busy_cycles"}, 64'(n), 64'(nb));
        chk({tag, "/done"}, {63'd0, done}, 64'd1);
        chk({tag, "/hilo"}, {hi, lo}, exp_hl);
        cur_hi = exp_hl[63:32];
        cur_lo = exp_hl[31:0];
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input string tag);
        logic [63:0] e;
        int          nb;
        e  = ref_md(op, a, b, cur_hi, cur_lo);
        nb = exp_busy(op, b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (nb > 0) begin
            wait_result(tag, nb, e);
            @(posedge clk); #1;
            chk({tag, "/done_fall"}, {63'd0, done}, 64'd0);
        end else begin
            chk({tag, "/busy"}, {63'd0, busy}, 64'd0);
            chk({tag, "/done"}, {63'd0, done}, 64'd0);
            chk({tag, "/hilo"}, {hi, lo}, e);
            cur_hi = e[63:32];
            cur_lo = e[31:0];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; cancel = 1'b0; hilo_rd = 1'b0;
        req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
        cur_hi = 32'd0; cur_lo = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/hilo", {hi, lo}, 64'd0);
        chk("reset/busy", {63'd0, busy}, 64'd0);
        chk("reset/done", {63'd0, done}, 64'd0);
        chk("reset/stall", {63'd0, stall}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic cases.
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("multu_max/const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        chk("mult_neg/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        chk("div_neg/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf/const", {hi, lo}, 64'h0000_0000_8000_0000);
        issue(MD_DIVU, 32'h1234, 32'd0, "divu_zero");
        chk("divu_zero/const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        issue(MD_MTLO, 32'h55, 32'd0, "mtlo");
        chk("mtlo/const", {32'd0, lo}, 64'h55);
        issue(MD_MTHI, 32'hA5A5_0001, 32'd0, "mthi");
        issue(3'd6, 32'h1111_2222, 32'd3, "op6_ignored");

        // Second DIVU held valid behind the first: taken in the done cycle.
        req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); #1;
        req_a = 32'd1000; req_b = 32'd33;
        wait_result("held1", 33, {32'd2, 32'd14});
        chk("held1/stall_done_cycle", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_result("held2", 33, ref_md(MD_DIVU, 32'd1000, 32'd33, cur_hi, cur_lo));
        @(posedge clk); #1;

        // Cancel around iteration 10 of a DIV.
        req_valid = 1'b1; req_op = MD_DIV; req_a = 32'hFFFF_FF9C; req_b = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel/busy", {63'd0, busy}, 64'd0);
        chk("cancel/hilo", {hi, lo}, {cur_hi, cur_lo});
        @(posedge clk); #1;
        chk("cancel/no_done", {63'd0, done}, 64'd0);

        // Cancel in IDLE drops the request.
        req_valid = 1'b1; req_op = MD_MTLO; req_a = 32'hDEAD_BEEF; cancel = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; cancel = 1'b0;
        chk("cancel_idle/lo", {32'd0, lo}, {32'd0, cur_lo});
        chk("cancel_idle/busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a MULT.
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd12345; req_b = 32'd6789;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid/busy", {63'd0, busy}, 64'd0);
        chk("rst_mid/hilo", {hi, lo}, 64'd0);
        chk("rst_mid/done", {63'd0, done}, 64'd0);
        cur_hi = 32'd0; cur_lo = 32'd0;
        @(posedge clk); #1;

        // Random ops with corner-biased operands.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
